// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 11-edge frame shift and ACK capture.
// Define PS2_TX_GLITCH_FILTER_EN to require 4 stable samples on the PS/2 clock before edge detection.
`timescale 1ns/1ps
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned TIMEOUT_CYCLES = 750000,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic       clock_fpga,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       send,
    output logic       busy,
    output logic       done,
    output logic       ack_ok,
    output logic       error,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int unsigned MaxCnt = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES
                                                                       : TIMEOUT_CYCLES;
    localparam int unsigned CntW = $clog2(MaxCnt + 1);
    localparam logic [CntW-1:0] InhLast   = CntW'(INHIBIT_CYCLES - 1);
    localparam logic [CntW-1:0] InhDataOn = CntW'(INHIBIT_CYCLES - 2);
    localparam logic [CntW-1:0] ToLast    = CntW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StInhibit,
        StRts,
        StShift,
        StAck,
        StWaitIdle
    } state_e;

    state_e state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [8:0] shift_q, shift_d;
    logic ack_bit_q, ack_bit_d;
    logic busy_q, busy_d;
    logic done_q, done_d;
    logic ack_ok_q, ack_ok_d;
    logic error_q, error_d;
    logic clk_oe_q, clk_oe_d;
    logic data_oe_q, data_oe_d;

    logic [SYNC_STAGES-1:0] clk_sync_q, data_sync_q;
    logic clk_s, data_s, clk_lvl, clk_lvl_q, fall;
    logic in_gap, wait_done;

    // Idle-high reset of the synchronizers avoids a false falling edge after reset.
    always_ff @(posedge clock_fpga) begin
        if (reset) begin
            clk_sync_q  <= '1;
            data_sync_q <= '1;
            clk_lvl_q   <= 1'b1;
        end else begin
            clk_sync_q[0]  <= ps2_clk_in;
            data_sync_q[0] <= ps2_data_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                clk_sync_q[i]  <= clk_sync_q[i-1];
                data_sync_q[i] <= data_sync_q[i-1];
            end
            clk_lvl_q <= clk_lvl;
        end
    end

    assign clk_s  = clk_sync_q[SYNC_STAGES-1];
    assign data_s = data_sync_q[SYNC_STAGES-1];

`ifdef PS2_TX_GLITCH_FILTER_EN
    logic [2:0] clk_hist_q;

    always_ff @(posedge clock_fpga) begin
        if (reset) begin
            clk_hist_q <= '1;
        end else begin
            clk_hist_q <= {clk_hist_q[1:0], clk_s};
        end
    end

    // New level is taken only once the current and three previous samples agree.
    always_comb begin
        clk_lvl = clk_lvl_q;
        if (clk_hist_q == {3{clk_s}}) begin
            clk_lvl = clk_s;
        end
    end
`else
    always_comb begin
        clk_lvl = clk_s;
    end
`endif

    assign fall      = clk_lvl_q & ~clk_lvl;
    assign in_gap    = (state_q == StRts) || (state_q == StShift) ||
                       (state_q == StAck) || (state_q == StWaitIdle);
    assign wait_done = (state_q == StWaitIdle) && clk_lvl && data_s;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        ack_bit_d = ack_bit_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        error_d   = 1'b0;
        ack_ok_d  = ack_ok_q;
        clk_oe_d  = clk_oe_q;
        data_oe_d = data_oe_q;

        unique case (state_q)
            StIdle: begin
                if (send) begin
                    shift_d   = {~^data_in, data_in};
                    busy_d    = 1'b1;
                    ack_ok_d  = 1'b0;
                    cnt_d     = '0;
                    bit_cnt_d = '0;
                    clk_oe_d  = 1'b1;
                    data_oe_d = (INHIBIT_CYCLES == 32'd1);
                    state_d   = StInhibit;
                end
            end
            StInhibit: begin
                if (cnt_q == InhLast) begin
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = StRts;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                    if (cnt_q == InhDataOn) begin
                        data_oe_d = 1'b1;
                    end
                end
            end
            StRts: begin
                if (fall) begin
                    data_oe_d = ~shift_q[0];
                    shift_d   = {1'b0, shift_q[8:1]};
                    bit_cnt_d = 4'd1;
                    state_d   = StShift;
                end
            end
            StShift: begin
                if (fall) begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd9) begin
                        data_oe_d = 1'b0;
                        state_d   = StAck;
                    end else begin
                        data_oe_d = ~shift_q[0];
                        shift_d   = {1'b0, shift_q[8:1]};
                    end
                end
            end
            StAck: begin
                if (fall) begin
                    ack_bit_d = ~data_s;
                    state_d   = StWaitIdle;
                end
            end
            StWaitIdle: begin
                if (wait_done) begin
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    ack_ok_d = ack_bit_q;
                    cnt_d    = '0;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Gap watchdog; a falling edge in the same cycle takes priority over the timeout.
        if (in_gap) begin
            if (fall) begin
                cnt_d = '0;
            end else if (!wait_done) begin
                if (cnt_q == ToLast) begin
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b0;
                    error_d   = 1'b1;
                    busy_d    = 1'b0;
                    ack_ok_d  = 1'b0;
                    cnt_d     = '0;
                    bit_cnt_d = '0;
                    state_d   = StIdle;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
        end
    end

    always_ff @(posedge clock_fpga) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            ack_bit_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ack_ok_q  <= 1'b0;
            error_q   <= 1'b0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            ack_bit_q <= ack_bit_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ack_ok_q  <= ack_ok_d;
            error_q   <= error_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign ack_ok      = ack_ok_q;
    assign error       = error_q;
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;

endmodule
